// File: rtl/token_injector_if.sv
// Command and handshake bundle for token_injector: command push side,
// self-timed SENDOUT/ACKIN channel, and status.
interface token_injector_if;
  logic       CMD_VALID;
  logic       CMD_READY;
  logic       CMD_EXB;
  logic       CMD_CPY;
  logic       SENDOUT;
  logic       EXBOUT;
  logic       CPYOUT;
  logic       ACKIN;
  logic       CLR_ERR;
  logic       BUSY;
  logic       ERR;
  logic [7:0] SENT_CNT;

  modport slave (
    input  CMD_VALID, CMD_EXB, CMD_CPY, ACKIN, CLR_ERR,
    output CMD_READY, SENDOUT, EXBOUT, CPYOUT, BUSY, ERR, SENT_CNT
  );

  modport master (
    output CMD_VALID, CMD_EXB, CMD_CPY, ACKIN, CLR_ERR,
    input  CMD_READY, SENDOUT, EXBOUT, CPYOUT, BUSY, ERR, SENT_CNT
  );
endinterface

// File: rtl/token_injector.sv
// Clocked-to-self-timed bridge: queues {EXB,CPY} commands and issues each one
// as a 4-phase return-to-zero token on SENDOUT/EXBOUT/CPYOUT against ACKIN.
module token_injector #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic           CLK,
  input  logic           RESETN,
  token_injector_if.slave bus
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_REQ  = 2'd2,
    ST_RTZ  = 2'd3
  } state_e;

  typedef struct packed {
    logic exb;
    logic cpy;
  } cmd_t;

  state_e                 state_q, state_d;
  cmd_t                   mem_q [DEPTH];
  cmd_t                   head;
  logic [AW-1:0]          wr_q, wr_d;
  logic [AW-1:0]          rd_q, rd_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ack_s;
  logic [TW-1:0]          timer_q, timer_d;
  logic                   ready_q, ready_d;
  logic                   busy_q, busy_d;
  logic                   send_q, send_d;
  logic                   exb_q, exb_d;
  logic                   cpy_q, cpy_d;
  logic                   err_q, err_d;
  logic [7:0]             sent_q, sent_d;
  logic                   push;
  logic                   pop;
  logic                   in_phase;

  assign ack_s = sync_q[SYNC_STAGES-1];
  assign head  = mem_q[rd_q];

  // Command storage; entries are only meaningful while counted by cnt_q
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_q[wr_q] <= cmd_t'{exb: bus.CMD_EXB, cpy: bus.CMD_CPY};
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d  = state_q;
    wr_d     = wr_q;
    rd_d     = rd_q;
    exb_d    = exb_q;
    cpy_d    = cpy_q;
    timer_d  = timer_q;
    err_d    = err_q;
    sent_d   = sent_q;
    push     = bus.CMD_VALID && ready_q;
    pop      = 1'b0;
    in_phase = (state_q == ST_REQ) || (state_q == ST_RTZ);

    unique case (state_q)
      ST_IDLE: begin
        if ((cnt_q != '0) && !ack_s) begin
          pop     = 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: state_d = ST_REQ;
      ST_REQ: begin
        if (ack_s) begin
          state_d = ST_RTZ;
        end
      end
      ST_RTZ: begin
        if (!ack_s) begin
          state_d = ST_IDLE;
          sent_d  = sent_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (push) begin
      wr_d = wr_q + AW'(1);
    end
    if (pop) begin
      rd_d  = rd_q + AW'(1);
      exb_d = head.exb;
      cpy_d = head.cpy;
    end
    cnt_d = cnt_q + CW'(push) - CW'(pop);

    // Phase timer saturates at TIMEOUT; the FSM keeps waiting regardless
    if ((state_d != state_q) || !in_phase) begin
      timer_d = '0;
    end else if (timer_q != TW'(TIMEOUT)) begin
      timer_d = timer_q + TW'(1);
    end

    if (bus.CLR_ERR) begin
      err_d = 1'b0;
    end
    if ((timer_d == TW'(TIMEOUT)) && (timer_q != TW'(TIMEOUT))) begin
      err_d = 1'b1;
    end

    ready_d = (cnt_d < CW'(DEPTH));
    busy_d  = (state_d != ST_IDLE) || (cnt_d != '0);
    send_d  = (state_d == ST_REQ);
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q <= ST_IDLE;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      sync_q  <= '0;
      timer_q <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      send_q  <= 1'b0;
      exb_q   <= 1'b0;
      cpy_q   <= 1'b0;
      err_q   <= 1'b0;
      sent_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      sync_q  <= {sync_q[SYNC_STAGES-2:0], bus.ACKIN};
      timer_q <= timer_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      send_q  <= send_d;
      exb_q   <= exb_d;
      cpy_q   <= cpy_d;
      err_q   <= err_d;
      sent_q  <= sent_d;
    end
  end

  assign bus.CMD_READY = ready_q;
  assign bus.BUSY      = busy_q;
  assign bus.SENDOUT   = send_q;
  assign bus.EXBOUT    = exb_q;
  assign bus.CPYOUT    = cpy_q;
  assign bus.ERR       = err_q;
  assign bus.SENT_CNT  = sent_q;

endmodule
